queue_seq_ctrl: RTL and testbench

- Sequencer between the serial deserializer and the byte queue inside TOP.
- Holds each completed deserializer word until the user issues an enqueue request.
- Converts the asynchronous enqueue_in/dequeue_in button levels into single-cycle queue commands and tracks queue occupancy.
- Drives status_out (ready for a new serial word) and data_out (last dequeued byte).

---
 rtl/queue_seq_ctrl_pkg.sv | 15 +
 rtl/queue_seq_ctrl_if.sv | 27 ++
 rtl/queue_seq_ctrl_edge_sync.sv | 29 ++
 rtl/queue_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_queue_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/queue_seq_ctrl_pkg.sv
// Shared definitions for the queue sequencer slice: controller state
// encoding and default geometry of the serial word / byte queue.
`timescale 1ns/1ps
package t3_pkg;
  localparam int DATA_W      = 8;
  localparam int QUEUE_DEPTH = 8;

  typedef enum logic [2:0] {
    S_RECV,
    S_HOLD,
    S_ENQ,
    S_DEQ,
    S_DCAP
  } ctrl_state_t;
endpackage

// File: rtl/queue_seq_ctrl_if.sv
// Bus between the sequencer, the deserializer and the byte queue.
//   des_data_i / des_valid_i : completed word from the deserializer
//   des_en_o                 : deserializer may shift in new bits
//   q_enq_o / q_wdata_o      : queue write strobe + data
//   q_deq_o / q_rdata_i      : queue read strobe, head data one cycle later
// master = sequencer side, slave = deserializer/queue side.
`timescale 1ns/1ps
interface queue_seq_ctrl_if #(
  parameter int DATA_W = t3_pkg::DATA_W
);
  logic [DATA_W-1:0] des_data_i;
  logic              des_valid_i;
  logic              des_en_o;
  logic              q_enq_o;
  logic [DATA_W-1:0] q_wdata_o;
  logic              q_deq_o;
  logic [DATA_W-1:0] q_rdata_i;

  modport master (
    input  des_data_i, des_valid_i, q_rdata_i,
    output des_en_o, q_enq_o, q_wdata_o, q_deq_o
  );
  modport slave (
    output des_data_i, des_valid_i, q_rdata_i,
    input  des_en_o, q_enq_o, q_wdata_o, q_deq_o
  );
endinterface

// File: rtl/queue_seq_ctrl_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk, rst  : clock, async active-high reset
//   i_async   : asynchronous level (button)
//   o_pulse   : one-cycle pulse per rising edge of i_async
// A rise first sampled at edge k makes o_pulse high between edges k+1
// and k+2, so the consuming logic acts on it at edge k+2.
`timescale 1ns/1ps
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_pulse
);
  logic r_s1, r_s2, r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_pulse = r_s2 & ~r_s3;
endmodule

// File: rtl/queue_seq_ctrl.sv
// Sequencer between the serial deserializer and the byte queue.
// Holds a completed word until an enqueue button press, turns button
// levels into single-cycle queue strobes and tracks queue occupancy.
//   clock_1MHz, rst : clock, async active-high reset
//   bus             : deserializer / queue bus (master side)
//   enqueue_in      : async button level, enqueue request
//   dequeue_in      : async button level, dequeue request
//   status_out      : high while waiting for a serial word
//   data_out        : last dequeued byte, held
//   len_out         : queue occupancy
//   err_o           : one-cycle pulse on an illegal or ignored request
`timescale 1ns/1ps
module queue_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = t3_pkg::QUEUE_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock_1MHz,
  input  logic              rst,
  queue_seq_ctrl_if.master  bus,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  output logic              status_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  len_out,
  output logic              err_o
);
  import t3_pkg::*;

  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

  ctrl_state_t       r_state, r_ret, w_nstate, w_nret;
  logic [DATA_W-1:0] r_hold, w_nhold;
  logic              r_pend, w_npend;
  logic [CNT_W-1:0]  r_cnt, w_ncnt;
  logic [DATA_W-1:0] r_data, w_ndata;
  logic              r_status, r_enq, r_deq, r_err, w_nerr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_enq_req, w_deq_req;

  edge_sync u_enq_sync (
    .clk(clock_1MHz), .rst(rst), .i_async(enqueue_in), .o_pulse(w_enq_req)
  );
  edge_sync u_deq_sync (
    .clk(clock_1MHz), .rst(rst), .i_async(dequeue_in), .o_pulse(w_deq_req)
  );

  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      r_state <= S_RECV;
      r_ret   <= S_RECV;
      r_hold  <= '0;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_ret   <= w_nret;
      r_hold  <= w_nhold;
      r_pend  <= w_npend;
      r_cnt   <= w_ncnt;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nret   = r_ret;
    w_nhold  = r_hold;
    w_npend  = r_pend;
    w_ncnt   = r_cnt;
    w_ndata  = r_data;
    w_nerr   = 1'b0;
    case (r_state)
      S_RECV: begin
        // nothing held yet, so an enqueue has nothing to write
        if (w_enq_req) w_nerr = 1'b1;
        if (bus.des_valid_i) begin
          w_nhold  = bus.des_data_i;
          w_nstate = S_HOLD;
        end
        if (w_deq_req) begin
          if (r_cnt != '0) begin
            // a word landing in the same cycle is kept: come back to HOLD
            w_nret   = bus.des_valid_i ? S_HOLD : S_RECV;
            w_nstate = S_DEQ;
          end else begin
            w_nerr = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus.des_valid_i) w_nerr = 1'b1;
        if (w_deq_req && r_cnt != '0) begin
          // dequeue wins; a simultaneous enqueue waits in pend
          w_nret   = S_HOLD;
          w_nstate = S_DEQ;
          if (w_enq_req) w_npend = 1'b1;
        end else begin
          if (w_deq_req) w_nerr = 1'b1;
          if (w_enq_req || r_pend) begin
            w_npend = 1'b0;
            if (r_cnt < L_DEPTH) w_nstate = S_ENQ;
            else                 w_nerr   = 1'b1;
          end
        end
      end
      S_ENQ: begin
        if (r_cnt < L_DEPTH) w_ncnt = r_cnt + CNT_W'(1);
        w_nstate = S_RECV;
        // the word is leaving, so no request can be kept here
        if (w_enq_req || w_deq_req || bus.des_valid_i) w_nerr = 1'b1;
      end
      S_DEQ, S_DCAP: begin
        if (r_state == S_DEQ) begin
          if (r_cnt != '0) w_ncnt = r_cnt - CNT_W'(1);
          w_nstate = S_DCAP;
        end else begin
          w_ndata  = bus.q_rdata_i;
          w_nstate = r_ret;
        end
        if (w_enq_req) begin
          if (r_ret == S_HOLD) w_npend = 1'b1;
          else                 w_nerr  = 1'b1;
        end
        if (w_deq_req || bus.des_valid_i) w_nerr = 1'b1;
      end
      default: w_nstate = S_RECV;
    endcase
  end

  // outputs are registered from the next state so they line up with it
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      r_status <= 1'b0;
      r_enq    <= 1'b0;
      r_wdata  <= '0;
      r_deq    <= 1'b0;
      r_data   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_status <= (w_nstate == S_RECV);
      r_enq    <= (w_nstate == S_ENQ);
      r_wdata  <= (w_nstate == S_ENQ) ? w_nhold : '0;
      r_deq    <= (w_nstate == S_DEQ);
      r_data   <= w_ndata;
      r_err    <= w_nerr;
    end
  end

  assign status_out    = r_status;
  assign bus.des_en_o  = r_status;
  assign bus.q_enq_o   = r_enq;
  assign bus.q_wdata_o = r_wdata;
  assign bus.q_deq_o   = r_deq;
  assign data_out      = r_data;
  assign len_out       = r_cnt;
  assign err_o         = r_err;
endmodule

// File: tb/tb_queue_seq_ctrl.sv
`timescale 1ns/1ps
module tb_queue_seq_ctrl;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clock_1MHz = 1'b1;
  logic          rst = 1'b1;
  logic          enqueue_in = 1'b0, dequeue_in = 1'b0;
  logic          status_out, err_o;
  logic [W-1:0]  data_out;
  logic [CW-1:0] len_out;

  queue_seq_ctrl_if #(.DATA_W(W)) bus();

  queue_seq_ctrl #(.DATA_W(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clock_1MHz(clock_1MHz), .rst(rst), .bus(bus),
    .enqueue_in(enqueue_in), .dequeue_in(dequeue_in),
    .status_out(status_out), .data_out(data_out),
    .len_out(len_out), .err_o(err_o)
  );

  always #500 clock_1MHz = ~clock_1MHz;

  // stand-in byte queue: head appears the cycle after the read strobe
  logic [W-1:0] fifo[$];
  always @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      fifo.delete();
      bus.q_rdata_i <= '0;
    end else begin
      if (bus.q_deq_o && fifo.size() > 0) begin
        bus.q_rdata_i <= fifo[0];
        void'(fifo.pop_front());
      end
      if (bus.q_enq_o) fifo.push_back(bus.q_wdata_o);
    end
  end

  int n_enq = 0, n_deq = 0, n_err = 0, n_overlap = 0;
  logic [W-1:0] last_wdata = '0;
  always @(posedge clock_1MHz) begin
    if (bus.q_enq_o) begin n_enq++; last_wdata = bus.q_wdata_o; end
    if (bus.q_deq_o) n_deq++;
    if (err_o) n_err++;
    if (bus.q_enq_o && bus.q_deq_o) n_overlap++;
  end

  int checks = 0, errors = 0;

  // reference model: queue contents, held word, last dequeued byte
  logic [W-1:0] m_q[$];
  bit           m_held = 0;
  logic [W-1:0] m_hold = '0, m_last = '0;

  task automatic tick(input int n);
    repeat (n) @(negedge clock_1MHz);
  endtask

  task automatic press(input bit e, input bit d, input int hold);
    @(negedge clock_1MHz);
    enqueue_in = e; dequeue_in = d;
    tick(hold);
    enqueue_in = 0; dequeue_in = 0;
    tick(12);
  endtask

  task automatic load(input logic [W-1:0] v);
    @(negedge clock_1MHz);
    bus.des_data_i = v; bus.des_valid_i = 1'b1;
    @(negedge clock_1MHz);
    bus.des_valid_i = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    #1000;
    checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL rst_status: got %0b exp 0", status_out); end
    checks++; if (bus.des_en_o !== 1'b0) begin errors++; $display("FAIL rst_des_en: got %0b exp 0", bus.des_en_o); end
    checks++; if (len_out !== '0) begin errors++; $display("FAIL rst_len: got %0d exp 0", len_out); end
    checks++; if (data_out !== '0 || err_o !== 1'b0 || bus.q_enq_o !== 1'b0 || bus.q_deq_o !== 1'b0)
      begin errors++; $display("FAIL rst_outs: data %0h err %0b enq %0b deq %0b exp all 0", data_out, err_o, bus.q_enq_o, bus.q_deq_o); end
    #1500; rst = 1'b0;
    #1;
    checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL rel_status_early: got %0b exp 0", status_out); end
    @(negedge clock_1MHz);
    checks++; if (status_out !== 1'b1 || bus.des_en_o !== 1'b1)
      begin errors++; $display("FAIL rel_status: got %0b/%0b exp 1/1", status_out, bus.des_en_o); end
    checks++; if (len_out !== '0 || data_out !== '0) begin errors++; $display("FAIL rel_len_data: got %0d/%0h exp 0/0", len_out, data_out); end
  endtask

  task automatic test_enq_basic();
    int e0, r0, lat;
    load(8'h99);
    checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL hold_status: got %0b exp 0", status_out); end
    e0 = n_enq; r0 = n_err; lat = -1;
    @(negedge clock_1MHz); enqueue_in = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock_1MHz);
      if (lat < 0 && bus.q_enq_o) lat = i;
    end
    enqueue_in = 1'b0; tick(12);
    checks++; if (lat != 3) begin errors++; $display("FAIL enq_latency: got %0d exp 3", lat); end
    checks++; if (n_enq - e0 != 1) begin errors++; $display("FAIL enq_count: got %0d exp 1", n_enq - e0); end
    checks++; if (last_wdata !== 8'h99) begin errors++; $display("FAIL enq_wdata: got %0h exp 99", last_wdata); end
    checks++; if (len_out !== CW'(1)) begin errors++; $display("FAIL enq_len: got %0d exp 1", len_out); end
    checks++; if (status_out !== 1'b1 || n_err != r0) begin errors++; $display("FAIL enq_status_err: got %0b/%0d exp 1/0", status_out, n_err - r0); end
    m_q.push_back(8'h99);
  endtask

  task automatic test_deq_basic();
    int d0, ld, lq;
    d0 = n_deq; ld = -1; lq = -1;
    @(negedge clock_1MHz); dequeue_in = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock_1MHz);
      if (lq < 0 && bus.q_deq_o) lq = i;
      if (ld < 0 && data_out === 8'h99) ld = i;
    end
    dequeue_in = 1'b0; tick(12);
    checks++; if (lq != 3) begin errors++; $display("FAIL deq_latency: got %0d exp 3", lq); end
    checks++; if (ld != 5) begin errors++; $display("FAIL data_latency: got %0d exp 5", ld); end
    checks++; if (n_deq - d0 != 1) begin errors++; $display("FAIL deq_count: got %0d exp 1", n_deq - d0); end
    checks++; if (data_out !== 8'h99 || len_out !== '0) begin errors++; $display("FAIL deq_data_len: got %0h/%0d exp 99/0", data_out, len_out); end
    void'(m_q.pop_front()); m_last = 8'h99;
  endtask

  task automatic test_errors();
    int e0, d0, r0;
    e0 = n_enq; d0 = n_deq; r0 = n_err;
    press(1'b0, 1'b1, 6);
    checks++; if (n_err - r0 != 1) begin errors++; $display("FAIL deq_empty_err: got %0d exp 1", n_err - r0); end
    checks++; if (data_out !== 8'h99 || len_out !== '0) begin errors++; $display("FAIL deq_empty_outs: got %0h/%0d exp 99/0", data_out, len_out); end
    r0 = n_err;
    press(1'b1, 1'b0, 6);
    checks++; if (n_err - r0 != 1) begin errors++; $display("FAIL enq_recv_err: got %0d exp 1", n_err - r0); end
    checks++; if (n_enq != e0 || n_deq != d0) begin errors++; $display("FAIL err_no_strobe: got %0d/%0d exp 0/0", n_enq - e0, n_deq - d0); end
    load(8'h5A);
    r0 = n_err;
    load(8'hA5);
    checks++; if (n_err - r0 != 1) begin errors++; $display("FAIL des_in_hold_err: got %0d exp 1", n_err - r0); end
    press(1'b1, 1'b0, 4);
    checks++; if (last_wdata !== 8'h5A) begin errors++; $display("FAIL hold_kept: got %0h exp 5a", last_wdata); end
    press(1'b0, 1'b1, 4);
    checks++; if (data_out !== 8'h5A || len_out !== '0) begin errors++; $display("FAIL hold_drain: got %0h/%0d exp 5a/0", data_out, len_out); end
    m_last = 8'h5A;
  endtask

  task automatic test_full();
    int e0, d0, r0, fe, fd;
    for (int i = 1; i <= 8; i++) begin
      load(W'(i));
      press(1'b1, 1'b0, 4);
    end
    checks++; if (len_out !== CW'(8)) begin errors++; $display("FAIL fill_len: got %0d exp 8", len_out); end
    load(8'h09);
    r0 = n_err; e0 = n_enq;
    press(1'b1, 1'b0, 4);
    checks++; if (n_err - r0 != 1 || n_enq != e0) begin errors++; $display("FAIL full_enq: err %0d enq %0d exp 1/0", n_err - r0, n_enq - e0); end
    checks++; if (len_out !== CW'(8) || status_out !== 1'b0) begin errors++; $display("FAIL full_hold: got %0d/%0b exp 8/0", len_out, status_out); end
    e0 = n_enq; d0 = n_deq; fe = -1; fd = -1;
    @(negedge clock_1MHz); enqueue_in = 1'b1; dequeue_in = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock_1MHz);
      if (fd < 0 && bus.q_deq_o) fd = i;
      if (fe < 0 && bus.q_enq_o) fe = i;
    end
    enqueue_in = 1'b0; dequeue_in = 1'b0; tick(12);
    checks++; if (fd < 0 || fe <= fd) begin errors++; $display("FAIL both_order: deq at %0d enq at %0d exp deq first", fd, fe); end
    checks++; if (n_enq - e0 != 1 || n_deq - d0 != 1) begin errors++; $display("FAIL both_count: got %0d/%0d exp 1/1", n_enq - e0, n_deq - d0); end
    checks++; if (last_wdata !== 8'h09 || data_out !== 8'h01) begin errors++; $display("FAIL both_data: got %0h/%0h exp 09/01", last_wdata, data_out); end
    checks++; if (len_out !== CW'(8) || status_out !== 1'b1) begin errors++; $display("FAIL both_len: got %0d/%0b exp 8/1", len_out, status_out); end
  endtask

  task automatic test_rst_mid();
    int r0;
    repeat (5) press(1'b0, 1'b1, 4);
    load(8'h77);
    checks++; if (len_out !== CW'(3) || status_out !== 1'b0) begin errors++; $display("FAIL pre_rst: got %0d/%0b exp 3/0", len_out, status_out); end
    @(negedge clock_1MHz); #200 rst = 1'b1; #1;
    checks++; if (status_out !== 1'b0 || bus.des_en_o !== 1'b0 || len_out !== '0 || data_out !== '0 ||
                  err_o !== 1'b0 || bus.q_enq_o !== 1'b0 || bus.q_deq_o !== 1'b0 || bus.q_wdata_o !== '0)
      begin errors++; $display("FAIL mid_rst_outs: st %0b len %0d data %0h exp all 0", status_out, len_out, data_out); end
    @(negedge clock_1MHz); rst = 1'b0; #1;
    checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL mid_rel_early: got %0b exp 0", status_out); end
    @(negedge clock_1MHz);
    checks++; if (status_out !== 1'b1 || len_out !== '0) begin errors++; $display("FAIL mid_rel: got %0b/%0d exp 1/0", status_out, len_out); end
    r0 = n_err;
    press(1'b1, 1'b0, 4);
    checks++; if (n_err - r0 != 1) begin errors++; $display("FAIL held_discarded: got %0d exp 1", n_err - r0); end
    m_q.delete(); m_held = 0; m_last = '0;
  endtask

  task automatic test_random();
    int op, e0, d0, r0, xe, xd, xr;
    logic [W-1:0] v, xw;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      e0 = n_enq; d0 = n_deq; r0 = n_err; xe = 0; xd = 0; xr = 0; xw = '0;
      v = W'($urandom);
      case (op)
        0: begin
          if (m_held) xr = 1; else begin m_held = 1; m_hold = v; end
          load(v);
        end
        default: begin
          if (op >= 2) begin
            if (m_q.size() > 0) begin m_last = m_q.pop_front(); xd = 1; end
            else xr = 1;
          end
          if (op == 1 || op == 3) begin
            if (m_held && m_q.size() < D) begin
              m_q.push_back(m_hold); m_held = 0; xe = 1; xw = m_hold;
            end else xr = 1;
          end
          press(op != 2, op >= 2, $urandom_range(2, 8));
        end
      endcase
      checks++; if (n_enq - e0 != xe || n_deq - d0 != xd || n_err - r0 != xr)
        begin errors++; $display("FAIL rnd%0d_op%0d strobes: enq %0d deq %0d err %0d exp %0d %0d %0d", n, op, n_enq - e0, n_deq - d0, n_err - r0, xe, xd, xr); end
      checks++; if (len_out !== CW'(m_q.size()) || status_out !== !m_held || data_out !== m_last)
        begin errors++; $display("FAIL rnd%0d_op%0d state: len %0d st %0b data %0h exp %0d %0b %0h", n, op, len_out, status_out, data_out, m_q.size(), !m_held, m_last); end
      if (xe == 1) begin
        checks++; if (last_wdata !== xw) begin errors++; $display("FAIL rnd%0d wdata: got %0h exp %0h", n, last_wdata, xw); end
      end
    end
    checks++; if (n_overlap != 0) begin errors++; $display("FAIL strobe_overlap: got %0d exp 0", n_overlap); end
  endtask

  initial begin
    bus.des_data_i = '0;
    bus.des_valid_i = 1'b0;
    test_reset();
    test_enq_basic();
    test_deq_basic();
    test_errors();
    test_full();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
